// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage.
// Holds the HLT encoding and the fetch FSM state type.
package cpu_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;

   localparam logic [31:0] HLT_INSN = 32'h0;

   typedef enum logic {
      FS_RUN,
      FS_HALT
   } fetch_state_t;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch and bubble event counters for the fetch stage.
// Both counters clear on reset and wrap naturally at 2^32.
module fetch_perf_ctr (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_evt,
   input  logic        bubble_evt,
   output logic [31:0] perf_fetch_o,
   output logic [31:0] perf_bubble_o
);

   logic [31:0] fetch_q;
   logic [31:0] bubble_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (fetch_evt)
            fetch_q <= fetch_q + 32'd1;
         if (bubble_evt)
            bubble_q <= bubble_q + 32'd1;
      end
   end

   assign perf_fetch_o  = fetch_q;
   assign perf_bubble_o = bubble_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, ROM addressing, IF/ID register, HLT freeze.
// Define FETCH_PERF_EN to add fetch/bubble performance counters.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   input  logic              id_ready_i,
   output logic              id_valid_o,
   output logic [DATA_W-1:0] id_instr_o,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic              halted_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetch_o,
   output logic [31:0]       perf_bubble_o
`endif
);

   fetch_state_t      state_q, state_n;
   logic [ADDR_W-1:0] pc_q, pc_n;
   logic              valid_q, valid_n;
   logic [DATA_W-1:0] instr_q, instr_n;
   logic [ADDR_W-1:0] id_pc_q, id_pc_n;
   logic              halted_q, halted_n;
   logic              load;
   logic              is_hlt;

   assign load   = !valid_q || id_ready_i;
   assign is_hlt = (rom_data_i == DATA_W'(HLT_INSN));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= FS_RUN;
         pc_q     <= ADDR_W'(RESET_PC);
         valid_q  <= 1'b0;
         instr_q  <= '0;
         id_pc_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_n;
         pc_q     <= pc_n;
         valid_q  <= valid_n;
         instr_q  <= instr_n;
         id_pc_q  <= id_pc_n;
         halted_q <= halted_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      pc_n     = pc_q;
      valid_n  = valid_q;
      instr_n  = instr_q;
      id_pc_n  = id_pc_q;
      halted_n = halted_q;
      unique case (state_q)
         FS_RUN: begin
            // a redirect squashes whatever is fetched this cycle, HLT included
            if (redirect_i) begin
               valid_n = 1'b0;
               pc_n    = redirect_pc_i;
            end else if (load) begin
               valid_n = 1'b1;
               instr_n = rom_data_i;
               id_pc_n = pc_q;
               if (is_hlt) begin
                  state_n  = FS_HALT;
                  halted_n = 1'b1;
               end else begin
                  pc_n = pc_q + ADDR_W'(1);
               end
            end
         end
         FS_HALT: begin
            halted_n = 1'b1;
            if (id_ready_i)
               valid_n = 1'b0;
         end
         default: begin
            state_n = FS_RUN;
         end
      endcase
   end

   assign rom_addr_o = pc_q;
   assign id_valid_o = valid_q;
   assign id_instr_o = instr_q;
   assign id_pc_o    = id_pc_q;
   assign halted_o   = halted_q;

`ifdef FETCH_PERF_EN
   logic fetch_evt;
   logic bubble_evt;

   assign fetch_evt  = (state_q == FS_RUN) && !redirect_i && load;
   assign bubble_evt = (state_q == FS_RUN) && !valid_q;

   fetch_perf_ctr u_perf (
      .clk           (clk),
      .rst_n         (rst_n),
      .fetch_evt     (fetch_evt),
      .bubble_evt    (bubble_evt),
      .perf_fetch_o  (perf_fetch_o),
      .perf_bubble_o (perf_bubble_o)
   );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed steps then random traffic.
// Compares every cycle against a behavioural fetch model.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rom_addr;
   logic [31:0] rom_data;
   logic        redirect;
   logic [4:0]  redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [4:0]  id_pc;
   logic        halted;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_bubble;
`endif

   logic [31:0] mem [32];

   int total = 0;
   int bad   = 0;

   // behavioural reference state
   int          m_pc;
   bit          m_valid;
   logic [31:0] m_instr;
   int          m_id_pc;
   bit          m_halt;
   logic [31:0] m_pf;
   logic [31:0] m_pb;

   fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rom_addr_o    (rom_addr),
      .rom_data_i    (rom_data),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .id_ready_i    (id_ready),
      .id_valid_o    (id_valid),
      .id_instr_o    (id_instr),
      .id_pc_o       (id_pc),
      .halted_o      (halted)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_o  (perf_fetch),
      .perf_bubble_o (perf_bubble)
`endif
   );

   assign rom_data = mem[rom_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit rd, input int rpc,
                             input bit rdy);
      logic [31:0] w;
      if (!r) begin
         m_pc = 0; m_valid = 0; m_instr = 0; m_id_pc = 0;
         m_halt = 0; m_pf = 0; m_pb = 0;
         return;
      end
      if (!m_halt && !m_valid) m_pb = m_pb + 1;
      if (m_halt) begin
         if (rdy) m_valid = 0;
      end else if (rd) begin
         m_valid = 0;
         m_pc = rpc;
      end else if (!m_valid || rdy) begin
         m_pf = m_pf + 1;
         w = mem[m_pc];
         m_valid = 1;
         m_instr = w;
         m_id_pc = m_pc;
         if (w == 32'h0) m_halt = 1;
         else m_pc = (m_pc + 1) % 32;
      end
   endtask

   task automatic cyc(input bit r, input bit rd, input int rpc,
                      input bit rdy);
      rst_n = r;
      redirect = rd;
      redirect_pc = rpc[4:0];
      id_ready = rdy;
      model_step(r, rd, rpc, rdy);
      @(posedge clk);
      #1;
      chk("rom_addr", 32'(rom_addr), 32'(m_pc));
      chk("id_valid", 32'(id_valid), 32'(m_valid));
      chk("id_pc", 32'(id_pc), 32'(m_id_pc));
      chk("halted", 32'(halted), 32'(m_halt));
      if (m_valid) chk("id_instr", id_instr, m_instr);
`ifdef FETCH_PERF_EN
      chk("perf_fetch", perf_fetch, m_pf);
      chk("perf_bubble", perf_bubble, m_pb);
`endif
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h111;
      mem[0]  = 32'h3463_0010;
      mem[1]  = 32'hac03_0000;
      mem[2]  = 32'hac00_0004;
      mem[24] = 32'h0;
      rst_n = 0; redirect = 0; redirect_pc = 0; id_ready = 1;

      // 1: reset then free-run
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_instr", id_instr, 32'h0);
      cyc(1, 0, 0, 1);
      chk("f0_pc", 32'(id_pc), 32'd0);
      chk("f0_instr", id_instr, 32'h3463_0010);
      cyc(1, 0, 0, 1);
      chk("f1_instr", id_instr, 32'hac03_0000);
      chk("f1_addr", 32'(rom_addr), 32'd2);

      // 2: stall
      repeat (3) cyc(1, 0, 0, 0);
      chk("stall_pc", 32'(id_pc), 32'd1);
      chk("stall_addr", 32'(rom_addr), 32'd2);
      cyc(1, 0, 0, 1);
      chk("rel_pc", 32'(id_pc), 32'd2);
      chk("rel_instr", id_instr, 32'hac00_0004);

      // 3: redirect onto HLT while stalled
      cyc(1, 1, 24, 0);
      chk("rd_valid", 32'(id_valid), 32'd0);
      chk("rd_addr", 32'(rom_addr), 32'd24);
      cyc(1, 0, 0, 0);
      chk("hlt_pc", 32'(id_pc), 32'd24);
      chk("hlt_instr", id_instr, 32'h0);
      chk("hlt_halted", 32'(halted), 32'd1);

      // 4: redirects ignored in HALT
      cyc(1, 1, 4, 0);
      cyc(1, 1, 4, 0);
      chk("halt_valid_held", 32'(id_valid), 32'd1);
      cyc(1, 1, 4, 1);
      chk("halt_drain", 32'(id_valid), 32'd0);
      cyc(1, 1, 4, 1);
      cyc(1, 1, 4, 1);
      chk("halt_addr", 32'(rom_addr), 32'd24);
      chk("halt_flag", 32'(halted), 32'd1);

      // 5: reset, redirect to 30, wrap
      cyc(0, 0, 0, 1);
      cyc(1, 1, 30, 1);
      cyc(1, 0, 0, 1);
      chk("wrap30", 32'(id_pc), 32'd30);
      cyc(1, 0, 0, 1);
      chk("wrap31", 32'(id_pc), 32'd31);
      cyc(1, 0, 0, 1);
      chk("wrap0", 32'(id_pc), 32'd0);
      cyc(1, 0, 0, 1);
      chk("wrap1", 32'(id_pc), 32'd1);
      chk("wrap_valid", 32'(id_valid), 32'd1);

      // 6: reset mid-stall
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("mid_rst_valid", 32'(id_valid), 32'd0);
      chk("mid_rst_addr", 32'(rom_addr), 32'd0);
      chk("mid_rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_EN
      chk("mid_rst_pf", perf_fetch, 32'd0);
      chk("mid_rst_pb", perf_bubble, 32'd0);
`endif
      cyc(1, 0, 0, 1);
      chk("restart_instr", id_instr, 32'h3463_0010);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         bit r, rd, rdy;
         int rpc;
         r   = ($urandom_range(0, 59) != 0);
         rd  = ($urandom_range(0, 7) == 0);
         rpc = int'($urandom_range(0, 31));
         rdy = ($urandom_range(0, 3) != 0);
         cyc(r, rd, rpc, rdy);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
